dino_game_sequencer: RTL and testbench

Frame-rate controller that sequences the dino and obstacle datapath through the game life-cycle: idle, run, dead and restart.
- Conditions raw button inputs into the single-frame jump and level duck commands consumed by the dino delegate.
- Issues the object-reset pulse.
- Schedules scroll speed and keeps the score.
- Sits between the button synchronisers, collision detector and the dino/obstacle delegates.

---
 rtl/dino_game_sequencer_pkg.sv | 13 +
 rtl/dino_game_sequencer_if.sv | 27 ++
 rtl/dino_game_sequencer_frame_divider.sv | 29 ++
 rtl/dino_game_sequencer.sv | 150 +++++++++++++++
 tb/tb_dino_game_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dino_game_sequencer_pkg.sv
// Shared types and widths for the dino game sequencer: game state encoding,
// score/speed widths and the score ceiling.
package dino_game_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } game_state_e;

  localparam int SCORE_W = 14;
  localparam int SPEED_W = 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;
endpackage

// File: rtl/dino_game_sequencer_if.sv
// Button/collision inputs and game-control outputs of the sequencer.
// slave = the sequencer itself, master = the surrounding game datapath.
interface dino_game_sequencer_if;
  import dino_game_pkg::*;

  logic               btnJump;
  logic               btnDuck;
  logic               collision;
  logic               onGround;
  logic               jump;
  logic               duck;
  logic               objRst;
  logic [SPEED_W-1:0] scrollSpeed;
  logic [SCORE_W-1:0] score;
  logic [1:0]         gameState;
  logic [SCORE_W-1:0] hiScore;

  modport slave (
    input  btnJump, btnDuck, collision, onGround,
    output jump, duck, objRst, scrollSpeed, score, gameState, hiScore
  );

  modport master (
    output btnJump, btnDuck, collision, onGround,
    input  jump, duck, objRst, scrollSpeed, score, gameState, hiScore
  );
endinterface

// File: rtl/dino_game_sequencer_frame_divider.sv
// Enable-gated wrap counter: tick is high in the enabled frame where the
// count sits at DIV-1, after which the count wraps to zero.
module frame_divider #(
  parameter int DIV = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) cnt_d = '0;
    else if (en)     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dino_game_sequencer.sv
// Game life-cycle sequencer (IDLE/RUN/DEAD): jump/duck conditioning, object
// reset, scroll speed and score. Optional best-score register: HISCORE_EN.
module dino_game_sequencer
  import dino_game_pkg::*;
#(
  parameter int SPEED_INIT        = 4,
  parameter int SPEED_MAX         = 12,
  parameter int SPEED_STEP_FRAMES = 600,
  parameter int SCORE_DIV         = 6,
  parameter int JUMP_BUF_FRAMES   = 6,
  parameter int DEAD_HOLD_FRAMES  = 60
) (
  input  logic                  FrameClk,
  input  logic                  rst,
  dino_game_sequencer_if.slave  bus
);
  localparam int BUF_W  = $clog2(JUMP_BUF_FRAMES + 1);
  localparam int HOLD_W = $clog2(DEAD_HOLD_FRAMES + 1);
  localparam logic [BUF_W-1:0]   BUF_LAST = BUF_W'(JUMP_BUF_FRAMES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_END = HOLD_W'(DEAD_HOLD_FRAMES);
  localparam logic [SPEED_W-1:0] SPD_INIT = SPEED_W'(SPEED_INIT);
  localparam logic [SPEED_W-1:0] SPD_MAX  = SPEED_W'(SPEED_MAX);

  game_state_e        state_q, state_d;
  logic               btn_jump_q, btn_jump_d;
  logic               jump_q, jump_d, duck_q, duck_d, obj_rst_q, obj_rst_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               pend_q, pend_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               j_press, start, fire, run_en, score_tick, speed_tick;

  assign j_press = bus.btnJump & ~btn_jump_q;
  // The dying frame does not count as a scoring frame.
  assign run_en  = (state_q == RUN) && !bus.collision;

  frame_divider #(.DIV(SCORE_DIV)) u_score_div (
    .clk(FrameClk), .rst(rst), .clr(start), .en(run_en), .tick(score_tick)
  );

  frame_divider #(.DIV(SPEED_STEP_FRAMES)) u_speed_div (
    .clk(FrameClk), .rst(rst), .clr(start), .en(run_en), .tick(speed_tick)
  );

  always_comb begin
    state_d    = state_q;
    btn_jump_d = bus.btnJump;
    jump_d     = 1'b0;
    duck_d     = 1'b0;
    obj_rst_d  = 1'b0;
    score_d    = score_q;
    speed_d    = speed_q;
    pend_d     = pend_q;
    buf_d      = buf_q;
    hold_d     = hold_q;
    start      = 1'b0;
    fire       = 1'b0;
    case (state_q)
      IDLE: start = j_press;
      RUN: begin
        if (bus.collision) begin
          state_d = DEAD;
          pend_d  = 1'b0;
          hold_d  = '0;
        end else begin
          fire   = bus.onGround & (j_press | pend_q);
          jump_d = fire;
          duck_d = bus.btnDuck & bus.onGround & ~fire;
          if (fire) pend_d = 1'b0;
          else if (j_press) begin
            pend_d = 1'b1;
            buf_d  = '0;
          end else if (pend_q) begin
            if (buf_q == BUF_LAST) pend_d = 1'b0;
            else                   buf_d  = buf_q + 1'b1;
          end
          if (score_tick && score_q != SCORE_MAX) score_d = score_q + 1'b1;
          if (speed_tick && speed_q < SPD_MAX)    speed_d = speed_q + 1'b1;
        end
      end
      DEAD: begin
        if (hold_q < HOLD_END) hold_d = hold_q + 1'b1;
        else                   start  = j_press;
      end
      default: state_d = IDLE;
    endcase
    // The start press also arms the jump buffer, so the dino jumps on the
    // first RUN frame after objRst has repositioned it.
    if (start) begin
      state_d   = RUN;
      obj_rst_d = 1'b1;
      score_d   = '0;
      speed_d   = SPD_INIT;
      pend_d    = 1'b1;
      buf_d     = '0;
    end
  end

  always_ff @(posedge FrameClk) begin
    if (rst) begin
      state_q    <= IDLE;
      btn_jump_q <= 1'b0;
      jump_q     <= 1'b0;
      duck_q     <= 1'b0;
      obj_rst_q  <= 1'b0;
      score_q    <= '0;
      speed_q    <= SPD_INIT;
      pend_q     <= 1'b0;
      buf_q      <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      btn_jump_q <= btn_jump_d;
      jump_q     <= jump_d;
      duck_q     <= duck_d;
      obj_rst_q  <= obj_rst_d;
      score_q    <= score_d;
      speed_q    <= speed_d;
      pend_q     <= pend_d;
      buf_q      <= buf_d;
      hold_q     <= hold_d;
    end
  end

`ifdef HISCORE_EN
  logic [SCORE_W-1:0] hi_q, hi_d;

  always_comb begin
    hi_d = hi_q;
    if (state_q == RUN && bus.collision && score_q > hi_q) hi_d = score_q;
  end

  always_ff @(posedge FrameClk) begin
    if (rst) hi_q <= '0;
    else     hi_q <= hi_d;
  end

  assign bus.hiScore = hi_q;
`else
  assign bus.hiScore = '0;
`endif

  assign bus.jump        = jump_q;
  assign bus.duck        = duck_q;
  assign bus.objRst      = obj_rst_q;
  assign bus.scrollSpeed = speed_q;
  assign bus.score       = score_q;
  assign bus.gameState   = state_q;
endmodule

// File: tb/tb_dino_game_sequencer.sv
// Bench for dino_game_sequencer: constant-expectation vector table, directed
// corner sequences and random frames checked against a frame-count model.
module tb_dino_game_sequencer;
  import dino_game_pkg::*;

  localparam int JB = 6, HOLD = 60, SDIV = 6, SSTEP = 600;

  logic FrameClk = 1'b0;
  logic rst = 1'b1;

  dino_game_sequencer_if bus();

  dino_game_sequencer dut (.FrameClk(FrameClk), .rst(rst), .bus(bus));

  always #5 FrameClk = ~FrameClk;

  int errors = 0;
  int checks = 0;

  // Reference model: score and speed follow from the number of RUN frames.
  int m_state, m_run, m_dead, m_hi, m_armed, m_fr;
  bit m_prev, m_pend, e_jump, e_duck, e_obj;

  function automatic int m_score();
    int s = m_run / SDIV;
    return (s > 9999) ? 9999 : s;
  endfunction

  function automatic int m_speed();
    int s = 4 + m_run / SSTEP;
    return (s > 12) ? 12 : s;
  endfunction

  function automatic int m_hiscore();
`ifdef HISCORE_EN
    return m_hi;
`else
    return 0;
`endif
  endfunction

  task automatic m_reset();
    m_state = 0; m_run = 0; m_dead = 0; m_hi = 0; m_armed = 0;
    m_prev = 1'b0; m_pend = 1'b0; e_jump = 1'b0; e_duck = 1'b0; e_obj = 1'b0;
  endtask

  task automatic m_step(input bit bj, input bit bd, input bit col, input bit og);
    bit jp, start, pv;
    jp = bj && !m_prev;
    start = 1'b0;
    m_prev = bj;
    e_jump = 1'b0; e_duck = 1'b0; e_obj = 1'b0;
    m_fr++;
    case (m_state)
      0: start = jp;
      1: begin
        if (col) begin
          if (m_score() > m_hi) m_hi = m_score();
          m_state = 2; m_dead = 0; m_pend = 1'b0;
        end else begin
          pv = m_pend && (m_fr - m_armed) >= 1 && (m_fr - m_armed) <= JB;
          e_jump = og && (jp || pv);
          e_duck = bd && og && !e_jump;
          if (e_jump) m_pend = 1'b0;
          else if (jp) begin m_pend = 1'b1; m_armed = m_fr; end
          m_run++;
        end
      end
      default: begin
        m_dead++;
        start = jp && (m_dead > HOLD);
      end
    endcase
    if (start) begin
      m_state = 1; m_run = 0; e_obj = 1'b1; m_pend = 1'b1; m_armed = m_fr;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("jump", int'(bus.jump), int'(e_jump));
    chk("duck", int'(bus.duck), int'(e_duck));
    chk("objRst", int'(bus.objRst), int'(e_obj));
    chk("scrollSpeed", int'(bus.scrollSpeed), m_speed());
    chk("score", int'(bus.score), m_score());
    chk("gameState", int'(bus.gameState), m_state);
    chk("hiScore", int'(bus.hiScore), m_hiscore());
  endtask

  task automatic step(input bit bj, input bit bd, input bit col, input bit og);
    bus.btnJump = bj; bus.btnDuck = bd; bus.collision = col; bus.onGround = og;
    @(posedge FrameClk);
    m_step(bj, bd, col, og);
    #1;
    chk_all();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.btnJump = 1'b0; bus.btnDuck = 1'b0; bus.collision = 1'b0; bus.onGround = 1'b0;
    repeat (n) @(posedge FrameClk);
    m_reset();
    #1;
    chk_all();
    rst = 1'b0;
  endtask

  typedef struct {
    bit bj, bd, col, og;
    int gs;
    bit j, d, o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit bj, bit bd, bit col, bit og, int gs, bit j, bit d, bit o);
    vec_t r;
    r.bj = bj; r.bd = bd; r.col = col; r.og = og;
    r.gs = gs; r.j = j; r.d = d; r.o = o;
    return r;
  endfunction

  task automatic air_frames(input int n);
    for (int k = 0; k < n; k++) tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0));
  endtask

  initial begin
    bit rb, rd, rc, ro;
    // Start press, then held button: exactly one jump.
    tbl.push_back(v(1, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(v(1, 0, 0, 1, 1, 1, 0, 0));
    for (int k = 0; k < 18; k++) tbl.push_back(v(1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 0, 0, 0));
    // Duck follows ground, suppressed by a jump.
    tbl.push_back(v(0, 1, 0, 1, 1, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 1, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0));
    // Air press, land at frame 4.
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0));
    air_frames(3);
    tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 0));
    // Air press, land at frame 8: expired.
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0));
    air_frames(7);
    tbl.push_back(v(0, 0, 0, 1, 1, 0, 0, 0));
    // Land at frame 6: last buffered frame.
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0));
    air_frames(5);
    tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 0));
    // Land at frame 7: first expired frame.
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0));
    air_frames(6);
    tbl.push_back(v(0, 0, 0, 1, 1, 0, 0, 0));
    // Re-press at frame 5 restarts the window; land at frame 11.
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0));
    air_frames(4);
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0));
    air_frames(5);
    tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 0, 0, 0));
    // Collision beats a simultaneous grounded jump press.
    tbl.push_back(v(1, 0, 1, 1, 2, 0, 0, 0));

    m_fr = 0;
    m_reset();
    do_reset(2);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
    chk("idle.gameState", int'(bus.gameState), 0);
    chk("idle.score", int'(bus.score), 0);
    chk("idle.scrollSpeed", int'(bus.scrollSpeed), 4);
    chk("idle.jump", int'(bus.jump), 0);
    chk("idle.objRst", int'(bus.objRst), 0);

    foreach (tbl[i]) begin
      step(tbl[i].bj, tbl[i].bd, tbl[i].col, tbl[i].og);
      chk($sformatf("tbl%0d.gameState", i), int'(bus.gameState), tbl[i].gs);
      chk($sformatf("tbl%0d.jump", i), int'(bus.jump), int'(tbl[i].j));
      chk($sformatf("tbl%0d.duck", i), int'(bus.duck), int'(tbl[i].d));
      chk($sformatf("tbl%0d.objRst", i), int'(bus.objRst), int'(tbl[i].o));
    end

    // DEAD: press at frame 30 ignored, press at frame 61 restarts.
    for (int d = 1; d <= 61; d++) begin
      step(d == 30 || d == 61, 0, 0, 1);
      if (d == 30) begin
        chk("dead30.gameState", int'(bus.gameState), 2);
        chk("dead30.objRst", int'(bus.objRst), 0);
      end
    end
    chk("restart.objRst", int'(bus.objRst), 1);
    chk("restart.gameState", int'(bus.gameState), 1);
    chk("restart.score", int'(bus.score), 0);
    step(0, 0, 0, 1);
    chk("restart.objRst_drop", int'(bus.objRst), 0);

    // Long run: score/speed schedule and speed saturation.
    do_reset(1);
    step(1, 0, 0, 1);
    for (int k = 1; k <= 5100; k++) begin
      rb = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 1) == 0);
      ro = ($urandom_range(0, 3) != 0);
      step(rb, rd, 0, ro);
      if (k == 599)  chk("run599.scrollSpeed", int'(bus.scrollSpeed), 4);
      if (k == 600)  chk("run600.scrollSpeed", int'(bus.scrollSpeed), 5);
      if (k == 3600) begin
        chk("run3600.score", int'(bus.score), 600);
        chk("run3600.scrollSpeed", int'(bus.scrollSpeed), 10);
      end
      if (k == 4800) chk("run4800.scrollSpeed", int'(bus.scrollSpeed), 12);
    end
    chk("run5100.scrollSpeed", int'(bus.scrollSpeed), 12);
    chk("run5100.score", int'(bus.score), 850);

    // Best score across two games, then reset mid-DEAD.
    do_reset(1);
    step(1, 0, 0, 1);
    for (int k = 0; k < 300; k++) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("die50.score", int'(bus.score), 50);
`ifdef HISCORE_EN
    chk("die50.hiScore", int'(bus.hiScore), 50);
`else
    chk("die50.hiScore", int'(bus.hiScore), 0);
`endif
    for (int d = 1; d <= 62; d++) begin
      step(d == 60 || d == 62, 0, 0, 1);
      if (d == 60) chk("dead60.gameState", int'(bus.gameState), 2);
    end
    chk("dead62.gameState", int'(bus.gameState), 1);
    for (int k = 0; k < 120; k++) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("die20.score", int'(bus.score), 20);
`ifdef HISCORE_EN
    chk("die20.hiScore", int'(bus.hiScore), 50);
`else
    chk("die20.hiScore", int'(bus.hiScore), 0);
`endif
    for (int d = 0; d < 10; d++) step(0, 0, 0, 1);
    do_reset(1);
    chk("rstdead.hiScore", int'(bus.hiScore), 0);
    chk("rstdead.gameState", int'(bus.gameState), 0);

    // Random frames against the model, with occasional resets.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 999) == 0) do_reset(1);
      else begin
        rb = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 1) == 0);
        rc = ($urandom_range(0, 149) == 0);
        ro = ($urandom_range(0, 2) != 0);
        step(rb, rd, rc, ro);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
